// File: rtl/issue_unit_pkg.sv
// Shared definitions for the Tomasulo issue stage.
// Covers tag constants, the pending-operand marker value, opcode encoding and the instruction field layout.
package issue_unit_pkg;

    localparam logic [2:0]  FREE_REGISTER    = 3'd0;
    localparam logic [2:0]  RES_STATION_ADD1 = 3'd1;
    localparam logic [2:0]  RES_STATION_ADD2 = 3'd2;
    localparam logic [15:0] Vj_Vk_sem_valor  = 16'hFFF0;

    localparam logic [1:0]  OP_SUB = 2'b01;

    localparam int OP_LSB = 6;
    localparam int RD_LSB = 4;
    localparam int RS_LSB = 2;
    localparam int RT_LSB = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
    } instr_t;

    function automatic instr_t decode_instr(input logic [7:0] raw);
        instr_t d;
        d.op = raw[OP_LSB +: 2];
        d.rd = raw[RD_LSB +: 2];
        d.rs = raw[RS_LSB +: 2];
        d.rt = raw[RT_LSB +: 2];
        return d;
    endfunction

    // op[1] set means NOP, whatever op[0] holds
    function automatic logic is_nop(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/issue_queue.sv
// In-order instruction FIFO for the issue stage.
// Pointers wrap naturally because DEPTH is a power of two. A push while full is dropped.
module issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is not reset; only the pointers and count define what is valid
    always_ff @(posedge Clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Tomasulo issue stage: queues instructions, allocates ADD1/ADD2, builds operands and renames Rd.
// Optional feature macro ISSUE_CDB_BYPASS_EN: when defined, a source that the CDB is broadcasting
// on the issue edge is captured directly. Otherwise issue waits one cycle for the status table.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Instr_valid,
    input  logic [7:0]               Instr_in,
    output logic                     Instr_ready,
    input  logic                     Busy_ADD1,
    input  logic                     Busy_ADD2,
    input  logic [7:0]               Rs_Qi_flat,
    input  logic [63:0]              Rs_Qi_data_flat,
    input  logic                     CDB_valid,
    input  logic [3:0]               Qi_CDB,
    input  logic [15:0]              Qi_CDB_data,
    output logic                     Issue_ADD1,
    output logic                     Issue_ADD2,
    output logic                     Issue_op,
    output logic [15:0]              Issue_Vj,
    output logic [15:0]              Issue_Vk,
    output logic [2:0]               Issue_Qj,
    output logic [2:0]               Issue_Qk,
    output logic                     R_enable_despacho,
    output logic [3:0]               R_target_despacho,
    output logic [3:0]               R_res_station_despacho,
    output logic [$clog2(QDEPTH):0] Queue_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]  r_state;
    logic        r_issue_add1, r_issue_add2, r_op, r_ren;
    logic [15:0] r_vj, r_vk;
    logic [2:0]  r_qj, r_qk;
    logic [3:0]  r_target, r_res;

    logic [7:0]  w_head_raw;
    instr_t      w_head;
    logic        w_full, w_empty, w_pop;
    logic [1:0]  w_qi_s, w_qi_t;
    logic [15:0] w_data_s, w_data_t;
    logic        w_hit_s, w_hit_t, w_cdb_stall;
    logic        w_head_nop, w_can_issue;
    logic [2:0]  w_station;
    logic [15:0] w_vj, w_vk;
    logic [2:0]  w_qj, w_qk;
    logic        w_unused_bits;

    issue_queue #(.DEPTH(QDEPTH), .WIDTH(8)) u_queue (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_push  (Instr_valid),
        .i_data  (Instr_in),
        .i_pop   (w_pop),
        .o_head  (w_head_raw),
        .o_count (Queue_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign Instr_ready = !w_full;
    assign w_head      = decode_instr(w_head_raw);
    assign w_head_nop  = is_nop(w_head.op);

    // Status-table lookups happen before this instruction renames Rd, so Rd==Rs sees the old entry
    assign w_qi_s   = Rs_Qi_flat[{w_head.rs, 1'b0} +: 2];
    assign w_qi_t   = Rs_Qi_flat[{w_head.rt, 1'b0} +: 2];
    assign w_data_s = Rs_Qi_data_flat[{w_head.rs, 4'b0000} +: 16];
    assign w_data_t = Rs_Qi_data_flat[{w_head.rt, 4'b0000} +: 16];

    assign w_hit_s = ({1'b0, w_qi_s} != FREE_REGISTER) && CDB_valid && ({1'b0, w_qi_s} == Qi_CDB[2:0]);
    assign w_hit_t = ({1'b0, w_qi_t} != FREE_REGISTER) && CDB_valid && ({1'b0, w_qi_t} == Qi_CDB[2:0]);

`ifdef ISSUE_CDB_BYPASS_EN
    assign w_cdb_stall = 1'b0;
`else
    assign w_cdb_stall = w_hit_s || w_hit_t;
`endif

    assign w_unused_bits = ^{Qi_CDB[3], Qi_CDB_data};

    assign w_station   = !Busy_ADD1 ? RES_STATION_ADD1 : RES_STATION_ADD2;
    assign w_can_issue = (r_state == ST_IDLE) && !w_empty && !w_head_nop
                         && (!Busy_ADD1 || !Busy_ADD2) && !w_cdb_stall;
    assign w_pop       = w_can_issue || ((r_state == ST_IDLE) && !w_empty && w_head_nop);

    // Operand build: ready value, CDB capture when bypass is enabled, else the pending marker value plus producer tag
    always_comb begin
        w_vj = Vj_Vk_sem_valor;
        w_qj = {1'b0, w_qi_s};
        w_vk = Vj_Vk_sem_valor;
        w_qk = {1'b0, w_qi_t};
        if ({1'b0, w_qi_s} == FREE_REGISTER) begin
            w_vj = w_data_s;
            w_qj = FREE_REGISTER;
        end
`ifdef ISSUE_CDB_BYPASS_EN
        else if (w_hit_s) begin
            w_vj = Qi_CDB_data;
            w_qj = FREE_REGISTER;
        end
`endif
        if ({1'b0, w_qi_t} == FREE_REGISTER) begin
            w_vk = w_data_t;
            w_qk = FREE_REGISTER;
        end
`ifdef ISSUE_CDB_BYPASS_EN
        else if (w_hit_t) begin
            w_vk = Qi_CDB_data;
            w_qk = FREE_REGISTER;
        end
`endif
    end

    // IDLE -> ISSUE -> SETTLE: outputs are held for one cycle, then a bubble lets status and Busy catch up
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_issue_add1 <= 1'b0;
            r_issue_add2 <= 1'b0;
            r_op         <= 1'b0;
            r_ren        <= 1'b0;
            r_vj         <= '0;
            r_vk         <= '0;
            r_qj         <= '0;
            r_qk         <= '0;
            r_target     <= '0;
            r_res        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_can_issue) begin
                        r_state      <= ST_ISSUE;
                        r_issue_add1 <= !Busy_ADD1;
                        r_issue_add2 <= Busy_ADD1;
                        r_op         <= (w_head.op == OP_SUB);
                        r_ren        <= 1'b1;
                        r_vj         <= w_vj;
                        r_vk         <= w_vk;
                        r_qj         <= w_qj;
                        r_qk         <= w_qk;
                        r_target     <= {2'b00, w_head.rd};
                        r_res        <= {1'b0, w_station};
                    end
                end
                ST_ISSUE: begin
                    r_issue_add1 <= 1'b0;
                    r_issue_add2 <= 1'b0;
                    r_ren        <= 1'b0;
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign Issue_ADD1             = r_issue_add1;
    assign Issue_ADD2             = r_issue_add2;
    assign Issue_op               = r_op;
    assign Issue_Vj               = r_vj;
    assign Issue_Vk               = r_vk;
    assign Issue_Qj               = r_qj;
    assign Issue_Qk               = r_qk;
    assign R_enable_despacho      = r_ren;
    assign R_target_despacho      = r_target;
    assign R_res_station_despacho = r_res;

endmodule

// File: tb/tb_issue_unit.sv
// Directed testbench for issue_unit: reset, ADD1/ADD2 allocation, full queue, NOP, CDB case, mid-issue reset.
// Expectations for the CDB case follow the ISSUE_CDB_BYPASS_EN macro.
module tb_issue_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Instr_valid;
    logic [7:0]  Instr_in;
    logic        Instr_ready;
    logic        Busy_ADD1, Busy_ADD2;
    logic [7:0]  Rs_Qi_flat;
    logic [63:0] Rs_Qi_data_flat;
    logic        CDB_valid;
    logic [3:0]  Qi_CDB;
    logic [15:0] Qi_CDB_data;
    logic        Issue_ADD1, Issue_ADD2, Issue_op;
    logic [15:0] Issue_Vj, Issue_Vk;
    logic [2:0]  Issue_Qj, Issue_Qk;
    logic        R_enable_despacho;
    logic [3:0]  R_target_despacho, R_res_station_despacho;
    logic [2:0]  Queue_count;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] REGS_DEFAULT = {16'd5, 16'd3, 16'd4, 16'd2};

    issue_unit dut (
        .Clock                  (Clock),
        .Reset                  (Reset),
        .Instr_valid            (Instr_valid),
        .Instr_in               (Instr_in),
        .Instr_ready            (Instr_ready),
        .Busy_ADD1              (Busy_ADD1),
        .Busy_ADD2              (Busy_ADD2),
        .Rs_Qi_flat             (Rs_Qi_flat),
        .Rs_Qi_data_flat        (Rs_Qi_data_flat),
        .CDB_valid              (CDB_valid),
        .Qi_CDB                 (Qi_CDB),
        .Qi_CDB_data            (Qi_CDB_data),
        .Issue_ADD1             (Issue_ADD1),
        .Issue_ADD2             (Issue_ADD2),
        .Issue_op               (Issue_op),
        .Issue_Vj               (Issue_Vj),
        .Issue_Vk               (Issue_Vk),
        .Issue_Qj               (Issue_Qj),
        .Issue_Qk               (Issue_Qk),
        .R_enable_despacho      (R_enable_despacho),
        .R_target_despacho      (R_target_despacho),
        .R_res_station_despacho (R_res_station_despacho),
        .Queue_count            (Queue_count)
    );

    always #5 Clock = ~Clock;

    task automatic push(input logic [7:0] ins);
        @(negedge Clock);
        Instr_valid = 1'b1;
        Instr_in    = ins;
        @(posedge Clock);
        #1;
        Instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Instr_valid = 1'b0; Instr_in = 8'h00;
        Busy_ADD1 = 1'b0; Busy_ADD2 = 1'b0;
        Rs_Qi_flat = 8'h00; Rs_Qi_data_flat = REGS_DEFAULT;
        CDB_valid = 1'b0; Qi_CDB = 4'd0; Qi_CDB_data = 16'd0;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({Queue_count, Instr_ready} !== {3'd0, 1'b1}) begin
            errors++; $display("[TB] FAIL reset_queue: got %h expected %h", {Queue_count, Instr_ready}, {3'd0, 1'b1});
        end
        checks++;
        if ({Issue_ADD1, Issue_ADD2, R_enable_despacho, Issue_op} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {Issue_ADD1, Issue_ADD2, R_enable_despacho, Issue_op});
        end
        checks++;
        if ({Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk, R_target_despacho, R_res_station_despacho} !== 46'd0) begin
            errors++; $display("[TB] FAIL reset_values: got %h expected 0", {Issue_Vj, Issue_Vk, Issue_Qj, Issue_Qk, R_target_despacho, R_res_station_despacho});
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_add_issue;
        push(8'h31);
        checks++;
        if (Queue_count !== 3'd1) begin
            errors++; $display("[TB] FAIL add_queued: got %0d expected 1", Queue_count);
        end
        @(posedge Clock); #1;
        checks++;
        if ({Issue_ADD1, Issue_ADD2, R_enable_despacho, Issue_op} !== 4'b1010) begin
            errors++; $display("[TB] FAIL add_strobes: got %b expected 1010", {Issue_ADD1, Issue_ADD2, R_enable_despacho, Issue_op});
        end
        checks++;
        if ({Issue_Vj, Issue_Vk} !== {16'd2, 16'd4}) begin
            errors++; $display("[TB] FAIL add_vjvk: got %h expected %h", {Issue_Vj, Issue_Vk}, {16'd2, 16'd4});
        end
        checks++;
        if ({Issue_Qj, Issue_Qk} !== 6'd0) begin
            errors++; $display("[TB] FAIL add_qjqk: got %h expected 0", {Issue_Qj, Issue_Qk});
        end
        checks++;
        if ({R_target_despacho, R_res_station_despacho, Queue_count} !== {4'd3, 4'd1, 3'd0}) begin
            errors++; $display("[TB] FAIL add_rename: got %h expected %h", {R_target_despacho, R_res_station_despacho, Queue_count}, {4'd3, 4'd1, 3'd0});
        end
        @(posedge Clock); #1;
        checks++;
        if ({Issue_ADD1, Issue_ADD2, R_enable_despacho} !== 3'b000) begin
            errors++; $display("[TB] FAIL add_one_cycle: got %b expected 000", {Issue_ADD1, Issue_ADD2, R_enable_despacho});
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_sub_add2;
        Rs_Qi_flat = 8'h04;
        Busy_ADD1  = 1'b1;
        push(8'h67);
        @(posedge Clock); #1;
        checks++;
        if ({Issue_ADD1, Issue_ADD2, R_enable_despacho, Issue_op} !== 4'b0111) begin
            errors++; $display("[TB] FAIL sub_strobes: got %b expected 0111", {Issue_ADD1, Issue_ADD2, R_enable_despacho, Issue_op});
        end
        checks++;
        if ({Issue_Vj, Issue_Qj, Issue_Vk, Issue_Qk} !== {16'hFFF0, 3'd1, 16'd5, 3'd0}) begin
            errors++; $display("[TB] FAIL sub_operands: got %h expected %h", {Issue_Vj, Issue_Qj, Issue_Vk, Issue_Qk}, {16'hFFF0, 3'd1, 16'd5, 3'd0});
        end
        checks++;
        if ({R_target_despacho, R_res_station_despacho} !== {4'd2, 4'd2}) begin
            errors++; $display("[TB] FAIL sub_rename: got %h expected 22", {R_target_despacho, R_res_station_despacho});
        end
        repeat (2) @(posedge Clock);
        #1;
        Rs_Qi_flat = 8'h00;
        Busy_ADD1  = 1'b0;
    endtask

    task automatic test_full_queue;
        Busy_ADD1 = 1'b1;
        Busy_ADD2 = 1'b1;
        for (int i = 0; i < 4; i++) push({2'b00, 2'(i), 2'd0, 2'd1});
        checks++;
        if ({Queue_count, Instr_ready} !== {3'd4, 1'b0}) begin
            errors++; $display("[TB] FAIL full_count: got %h expected %h", {Queue_count, Instr_ready}, {3'd4, 1'b0});
        end
        push(8'h05);
        checks++;
        if (Queue_count !== 3'd4) begin
            errors++; $display("[TB] FAIL full_push_ignored: got %0d expected 4", Queue_count);
        end
        Busy_ADD1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock); #1;
            checks++;
            if ({Issue_ADD1, R_target_despacho, Queue_count} !== {1'b1, 4'(k), 3'(3 - k)}) begin
                errors++; $display("[TB] FAIL full_order_%0d: got %h expected %h", k, {Issue_ADD1, R_target_despacho, Queue_count}, {1'b1, 4'(k), 3'(3 - k)});
            end
            @(posedge Clock); #1;
            checks++;
            if (Issue_ADD1 !== 1'b0) begin
                errors++; $display("[TB] FAIL full_spacing_%0d: got %b expected 0", k, Issue_ADD1);
            end
            @(posedge Clock); #1;
        end
        repeat (3) begin
            @(posedge Clock); #1;
            checks++;
            if ({Issue_ADD1, Issue_ADD2, R_enable_despacho, Queue_count} !== {3'b000, 3'd0}) begin
                errors++; $display("[TB] FAIL full_no_extra: got %h expected 0", {Issue_ADD1, Issue_ADD2, R_enable_despacho, Queue_count});
            end
        end
    endtask

    task automatic test_nop;
        Busy_ADD1 = 1'b1;
        Busy_ADD2 = 1'b1;
        push(8'h80);
        checks++;
        if (Queue_count !== 3'd1) begin
            errors++; $display("[TB] FAIL nop_queued: got %0d expected 1", Queue_count);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge Clock); #1;
            checks++;
            if ({Issue_ADD1, Issue_ADD2, R_enable_despacho, Queue_count} !== {3'b000, 3'd0}) begin
                errors++; $display("[TB] FAIL nop_pop_%0d: got %h expected 0", c, {Issue_ADD1, Issue_ADD2, R_enable_despacho, Queue_count});
            end
        end
        Busy_ADD1 = 1'b0;
        Busy_ADD2 = 1'b0;
    endtask

    task automatic test_cdb;
        Rs_Qi_flat = 8'h01;
        push(8'h31);
        CDB_valid   = 1'b1;
        Qi_CDB      = 4'd1;
        Qi_CDB_data = 16'd9;
        @(posedge Clock); #1;
`ifdef ISSUE_CDB_BYPASS_EN
        checks++;
        if ({Issue_ADD1, Issue_Vj, Issue_Qj, Issue_Vk, Issue_Qk} !== {1'b1, 16'd9, 3'd0, 16'd4, 3'd0}) begin
            errors++; $display("[TB] FAIL cdb_bypass: got %h expected %h", {Issue_ADD1, Issue_Vj, Issue_Qj, Issue_Vk, Issue_Qk}, {1'b1, 16'd9, 3'd0, 16'd4, 3'd0});
        end
        CDB_valid = 1'b0;
`else
        checks++;
        if ({Issue_ADD1, Queue_count} !== {1'b0, 3'd1}) begin
            errors++; $display("[TB] FAIL cdb_stall: got %h expected %h", {Issue_ADD1, Queue_count}, {1'b0, 3'd1});
        end
        CDB_valid  = 1'b0;
        Rs_Qi_flat = 8'h00;
        Rs_Qi_data_flat[15:0] = 16'd9;
        @(posedge Clock); #1;
        checks++;
        if ({Issue_ADD1, Issue_Vj, Issue_Qj, Issue_Vk, Issue_Qk} !== {1'b1, 16'd9, 3'd0, 16'd4, 3'd0}) begin
            errors++; $display("[TB] FAIL cdb_reread: got %h expected %h", {Issue_ADD1, Issue_Vj, Issue_Qj, Issue_Vk, Issue_Qk}, {1'b1, 16'd9, 3'd0, 16'd4, 3'd0});
        end
`endif
        repeat (2) @(posedge Clock);
        #1;
        Rs_Qi_flat      = 8'h00;
        Rs_Qi_data_flat = REGS_DEFAULT;
    endtask

    task automatic test_reset_mid_issue;
        Busy_ADD1 = 1'b1;
        Busy_ADD2 = 1'b1;
        push(8'h31);
        push(8'h67);
        Busy_ADD1 = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if ({Issue_ADD1, Queue_count} !== {1'b1, 3'd1}) begin
            errors++; $display("[TB] FAIL rst_mid_issue: got %h expected %h", {Issue_ADD1, Queue_count}, {1'b1, 3'd1});
        end
        Reset = 1'b1;
        #1;
        checks++;
        if ({Issue_ADD1, Issue_ADD2, R_enable_despacho, Queue_count, Instr_ready} !== {3'b000, 3'd0, 1'b1}) begin
            errors++; $display("[TB] FAIL rst_mid_clear: got %h expected %h", {Issue_ADD1, Issue_ADD2, R_enable_despacho, Queue_count, Instr_ready}, {3'b000, 3'd0, 1'b1});
        end
        checks++;
        if ({Issue_Vj, Issue_Vk, R_target_despacho, R_res_station_despacho} !== 40'd0) begin
            errors++; $display("[TB] FAIL rst_mid_values: got %h expected 0", {Issue_Vj, Issue_Vk, R_target_despacho, R_res_station_despacho});
        end
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clock); #1;
            checks++;
            if ({Issue_ADD1, Issue_ADD2, R_enable_despacho} !== 3'b000) begin
                errors++; $display("[TB] FAIL rst_mid_no_pulse_%0d: got %b expected 000", c, {Issue_ADD1, Issue_ADD2, R_enable_despacho});
            end
        end
    endtask

    initial begin
        $display("[TB] starting issue_unit tests");
        test_reset();
        test_add_issue();
        test_sub_add2();
        test_full_queue();
        test_nop();
        test_cdb();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
